// File: rtl/aos_softreg_router_tracked.sv
// SoftReg router: host port to SR_NUM_APPS application slots.
// Decodes the app index from the address, masks the routing bits from the
// address seen by the app, tracks a single outstanding read and returns an
// error word for invalid/disabled targets. A saturating error counter is
// provided for debug.
// Optional feature macro: AOS_SR_TIMEOUT_EN enables the read-response timer.
// SoftReg structs are carried as flat fields; per-slot fields are packed
// with slot i occupying bits [i*W +: W].
module aos_softreg_router_tracked #(
  parameter int          SR_NUM_APPS    = 4,
  parameter int          APP_SEL_LSB    = 10,
  parameter int          APP_SEL_BITS   = 6,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [63:0] ERR_DATA       = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SR_NUM_APPS-1:0]    app_enable,
  input  logic                      softreg_req_valid,
  input  logic                      softreg_req_is_write,
  input  logic [31:0]               softreg_req_addr,
  input  logic [63:0]               softreg_req_data,
  output logic                      softreg_resp_valid,
  output logic [63:0]               softreg_resp_data,
  output logic [SR_NUM_APPS-1:0]    app_softreg_req_valid,
  output logic [SR_NUM_APPS-1:0]    app_softreg_req_is_write,
  output logic [SR_NUM_APPS*32-1:0] app_softreg_req_addr,
  output logic [SR_NUM_APPS*64-1:0] app_softreg_req_data,
  input  logic [SR_NUM_APPS-1:0]    app_softreg_resp_valid,
  input  logic [SR_NUM_APPS*64-1:0] app_softreg_resp_data,
  output logic [15:0]               err_count
);

  localparam logic [31:0] ADDR_MASK = (32'd1 << APP_SEL_LSB) - 32'd1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_t;

  state_t                   state, state_d;
  logic [SR_NUM_APPS-1:0]   tgt_hot, tgt_hot_d;
  logic [APP_SEL_BITS-1:0]  sel;
  logic [SR_NUM_APPS-1:0]   sel_hot;
  logic                     target_valid;
  logic [SR_NUM_APPS-1:0]   fwd_vec_d;
  logic                     resp_valid_d;
  logic [63:0]              resp_data_d;
  logic                     err_evt;
  logic                     tgt_resp_valid;
  logic [63:0]              tgt_resp_data;
  logic                     spurious;
  logic [31:0]              masked_addr;
  logic                     unused_addr_bits;
`ifdef AOS_SR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] timer, timer_d;
`endif

  // Address bits above the select field carry no meaning for routing.
  assign unused_addr_bits = ^softreg_req_addr;
  assign sel         = softreg_req_addr[APP_SEL_LSB +: APP_SEL_BITS];
  assign masked_addr = softreg_req_addr & ADDR_MASK;

  // Decode the select field to a one-hot slot vector and pick the target's response.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sel_hot       = '0;
    tgt_resp_data = '0;
    for (int i = 0; i < SR_NUM_APPS; i++) begin
      if (sel == APP_SEL_BITS'(i)) sel_hot[i] = 1'b1;
      if (tgt_hot[i]) tgt_resp_data = app_softreg_resp_data[i*64 +: 64];
    end
  end

  assign target_valid   = |(sel_hot & app_enable);
  assign tgt_resp_valid = (state == S_WAIT) && |(app_softreg_resp_valid & tgt_hot);
  assign spurious       = |(app_softreg_resp_valid &
                            ~((state == S_WAIT) ? tgt_hot : {SR_NUM_APPS{1'b0}}));

  // Next-state, forwarding, host response and error-event logic.
  always_comb begin
    state_d      = state;
    tgt_hot_d    = tgt_hot;
    fwd_vec_d    = '0;
    resp_valid_d = 1'b0;
    resp_data_d  = '0;
    err_evt      = spurious;
`ifdef AOS_SR_TIMEOUT_EN
    timer_d      = timer;
`endif
    // Writes route on every state; invalid targets are dropped and counted.
    if (softreg_req_valid && softreg_req_is_write) begin
      if (target_valid) fwd_vec_d = sel_hot;
      else              err_evt   = 1'b1;
    end
    unique case (state)
      S_IDLE: begin
        if (softreg_req_valid && !softreg_req_is_write) begin
          if (target_valid) begin
            fwd_vec_d = sel_hot;
            tgt_hot_d = sel_hot;
            state_d   = S_WAIT;
`ifdef AOS_SR_TIMEOUT_EN
            timer_d   = '0;
`endif
          end else begin
            resp_valid_d = 1'b1;
            resp_data_d  = ERR_DATA;
            err_evt      = 1'b1;
            state_d      = S_ERR;
          end
        end
      end
      S_WAIT: begin
        if (softreg_req_valid && !softreg_req_is_write) err_evt = 1'b1;
        // A response on the timeout edge takes priority over the timeout.
        if (tgt_resp_valid) begin
          resp_valid_d = 1'b1;
          resp_data_d  = tgt_resp_data;
          state_d      = S_IDLE;
        end
`ifdef AOS_SR_TIMEOUT_EN
        else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          resp_valid_d = 1'b1;
          resp_data_d  = ERR_DATA;
          err_evt      = 1'b1;
          state_d      = S_IDLE;
        end else begin
          timer_d = timer + 1'b1;
        end
`endif
      end
      S_ERR: begin
        if (softreg_req_valid && !softreg_req_is_write) err_evt = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, tracker and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state                    <= S_IDLE;
      tgt_hot                  <= '0;
      softreg_resp_valid       <= 1'b0;
      softreg_resp_data        <= '0;
      app_softreg_req_valid    <= '0;
      app_softreg_req_is_write <= '0;
      app_softreg_req_addr     <= '0;
      app_softreg_req_data     <= '0;
      err_count                <= '0;
`ifdef AOS_SR_TIMEOUT_EN
      timer                    <= '0;
`endif
    end else begin
      state              <= state_d;
      tgt_hot            <= tgt_hot_d;
      softreg_resp_valid <= resp_valid_d;
      softreg_resp_data  <= resp_data_d;
      for (int i = 0; i < SR_NUM_APPS; i++) begin
        app_softreg_req_valid[i]        <= fwd_vec_d[i];
        app_softreg_req_is_write[i]     <= fwd_vec_d[i] & softreg_req_is_write;
        app_softreg_req_addr[i*32 +: 32] <= fwd_vec_d[i] ? masked_addr : 32'd0;
        app_softreg_req_data[i*64 +: 64] <= fwd_vec_d[i] ? softreg_req_data : 64'd0;
      end
      if (err_evt && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
`ifdef AOS_SR_TIMEOUT_EN
      timer <= timer_d;
`endif
    end
  end

endmodule
